adv7513_cfg_seq: RTL and testbench
==================================

# adv7513_cfg_seq

Configuration sequencer for the ADV7513 HDMI transmitter. After a power-up settle delay it walks a register-init ROM and issues one I2C register write per entry to the shared I2C master, retrying NACKed writes. When the table completes it enables the video timing driver through `drvr_en`. It sits between the vcortex control path, the I2C master and the ADV7513 video driver.

## Interface
Parameters:
- `NUM_REGS`, 16: number of ROM entries to write (≥1).
- `I2C_DEV_ADDR`, 8'h72: ADV7513 8-bit write address driven on every request.
- `MAX_RETRY`, 3: NACK retries per entry before abort (≥0).
- `PWRUP_WAIT`, 1000000: settle cycles after start before the first write (≥1).

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, synchronous and active-low.
- `cfg_start` in 1: one-cycle pulse that starts or restarts configuration. Ignored while busy.
- `hpd` in 1: hot-plug-detect level, already synchronised to `clk`.
- `rom_addr` out $clog2(NUM_REGS): ROM entry index.
- `rom_rdata` in 16: {reg_addr[15:8], data[7:0]}, valid 1 cycle after `rom_addr`.
- `i2c_req` out 1: write request, held until `i2c_done`.
- `i2c_dev_addr` out 8: always `I2C_DEV_ADDR`.
- `i2c_reg_addr` out 8: register address of the current entry.
- `i2c_wdata` out 8: data byte of the current entry.
- `i2c_done` in 1: one-cycle completion pulse from the I2C master.
- `i2c_nack` in 1: qualifies `i2c_done`; 1 means NACK.
- `busy` out 1: high in any state except IDLE, DONE and ERR.
- `cfg_done` out 1: level, high in DONE.
- `cfg_err` out 1: level, high in ERR.
- `drvr_en` out 1: enable to the video driver; equals `cfg_done`.

## Operation
States:
- **IDLE**
  - `cfg_start & hpd` → WAIT.
  - `cfg_start & ~hpd` → stays IDLE.
  - On entry, clears the wait counter, ROM index and retry counter.
- **WAIT**: wait counter counts 0..PWRUP_WAIT-1. At terminal count → ROM_RD.
- **ROM_RD**: drives `rom_addr` = index → ROM_LAT.
- **ROM_LAT**: registers `rom_rdata` into `i2c_reg_addr` / `i2c_wdata` → REQ.
- **REQ**: `i2c_req` = 1 and held at 1 until `i2c_done`. Address and data stay stable.
  - `i2c_done & ~i2c_nack`:
    - index == NUM_REGS-1 → DONE.
    - otherwise index+1, retry cleared → ROM_RD.
  - `i2c_done & i2c_nack`:
    - retry < MAX_RETRY → retry+1, → REQ_GAP.
    - retry == MAX_RETRY → ERR.
- **REQ_GAP**: one cycle with `i2c_req` = 0, then → REQ, reissuing the same entry.
- **DONE**: `drvr_en` = 1.
  - `cfg_start` → WAIT (full reconfiguration).
  - `hpd` falling: see Configuration.
- **ERR**: `cfg_err` = 1. `cfg_start & hpd` → WAIT.

Rules:
- Any state, `hpd` = 0 while `busy` → IDLE. `i2c_req` drops the same cycle the state changes.
- Counters:
  - Wait counter: $clog2(PWRUP_WAIT) bits. It does not wrap; it is cleared on entry to WAIT.
  - Retry counter: $clog2(MAX_RETRY+1) bits, with a minimum of 1 bit.
- `i2c_done` outside REQ is ignored.
- A `cfg_start` arriving in the same cycle as `i2c_done` in REQ is ignored.

## Timing
- Reset (`rst_n` = 0 at a `clk` edge): state IDLE.
  - `i2c_req`, `busy`, `cfg_done`, `cfg_err`, `drvr_en` = 0.
  - `rom_addr`, `i2c_reg_addr`, `i2c_wdata` = 0.
  - `i2c_dev_addr` = `I2C_DEV_ADDR`.
- All outputs are registered.
- `cfg_start` sampled at edge N → `busy` = 1 at N+1.
- First `i2c_req` rises PWRUP_WAIT+2 cycles after entering WAIT.
- After an ACKed `i2c_done` at edge M, the next `i2c_req` rises at M+3 (ROM_RD, ROM_LAT, REQ).
- After a NACK, the re-request rises at M+2.
- `drvr_en` rises the cycle after the final ACKed `i2c_done`.
- `drvr_en` falls the cycle after `cfg_start` is taken in DONE, or after the `hpd` drop in DONE (with `ADV7513_HPD_RECFG_EN`).
- A reset asserted mid-transaction drops `i2c_req` at the next edge. The I2C master must tolerate request withdrawal.

## Configuration
- `ADV7513_HPD_RECFG_EN` defined:
  - In DONE, `hpd` = 0 → IDLE and `drvr_en` drops.
  - In IDLE, a rising `hpd` (registered previous value = 0, current = 1) acts as `cfg_start`.
  - Effect: hot-plug triggers automatic reconfiguration.
- Not defined:
  - `hpd` is ignored in DONE and `drvr_en` stays high.
  - Only `cfg_start` restarts configuration.
  - `hpd` still gates `cfg_start` in IDLE/ERR and aborts busy states.

## Test plan
- **Nominal.** NUM_REGS=4, PWRUP_WAIT=10, ROM {0x4110,0x9803,0x9A70,0x9C30}, `hpd` = 1, every write ACKed after 5 cycles. Expect exactly 4 requests in ROM order, each with `i2c_dev_addr` = 0x72, then `drvr_en` = 1 with `cfg_done` = 1.
- **Retry.** MAX_RETRY=2, entry 1 NACKed twice then ACKed. Expect the same {0x98,0x03} issued 3 times, each re-request separated by a 1-cycle low, then completion.
- **Abort.** MAX_RETRY=2, entry 2 always NACKed. Expect 3 attempts, then `cfg_err` = 1, `drvr_en` = 0, `busy` = 0, and no further requests.
- **HPD abort.** `hpd` drops while REQ is pending. Expect `i2c_req` = 0 the next cycle and state IDLE. A later `cfg_start` with `hpd` = 1 restarts from entry 0.
- **HPD in DONE.** `hpd` toggles 1→0→1 while in DONE. With `ADV7513_HPD_RECFG_EN`: `drvr_en` falls, then the full sequence reruns. Without it: `drvr_en` stays 1 and no requests are issued.
- **Reset mid-WAIT.** `rst_n` = 0 for 1 cycle partway through WAIT. Expect all outputs at their reset values and no request until a new `cfg_start`.

Source files
------------

// File: rtl/adv7513_cfg_seq.sv
// adv7513_cfg_seq: ADV7513 HDMI transmitter configuration sequencer.
// Waits a power-up settle time, then writes every register-init ROM entry
// through the shared I2C master (retrying NACKs) and finally enables the
// video timing driver.
// Optional build macro: ADV7513_HPD_RECFG_EN (hot-plug driven reconfiguration).
module adv7513_cfg_seq #(
  parameter int unsigned NUM_REGS     = 16,
  parameter logic [7:0]  I2C_DEV_ADDR = 8'h72,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned PWRUP_WAIT   = 1000000
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              cfg_start,
  input  logic                                              hpd,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] rom_addr,
  input  logic [15:0]                                       rom_rdata,
  output logic                                              i2c_req,
  output logic [7:0]                                        i2c_dev_addr,
  output logic [7:0]                                        i2c_reg_addr,
  output logic [7:0]                                        i2c_wdata,
  input  logic                                              i2c_done,
  input  logic                                              i2c_nack,
  output logic                                              busy,
  output logic                                              cfg_done,
  output logic                                              cfg_err,
  output logic                                              drvr_en
);

  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned WW = (PWRUP_WAIT > 1) ? $clog2(PWRUP_WAIT) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REGS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(PWRUP_WAIT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ROM_RD  = 3'd2;
  localparam logic [2:0] S_ROM_LAT = 3'd3;
  localparam logic [2:0] S_REQ     = 3'd4;
  localparam logic [2:0] S_REQ_GAP = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [WW-1:0] r_wait_cnt;
  logic [RW-1:0] r_retry;
  logic          r_req;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [7:0]    r_dev_addr;
  logic [7:0]    r_reg_addr;
  logic [7:0]    r_wdata;

  logic w_busy_st;
  logic w_wait_tc;
  logic w_last;
  logic w_retry_max;
  logic w_start_idle;
  logic w_enter_wait;

  assign w_busy_st    = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign w_wait_tc    = (r_wait_cnt == WAIT_LAST);
  assign w_last       = (r_idx == IDX_LAST);
  assign w_retry_max  = (r_retry >= RETRY_MAX);
  assign w_enter_wait = (w_state_nxt == S_WAIT) && (r_state != S_WAIT);

`ifdef ADV7513_HPD_RECFG_EN
  logic r_hpd_q;

  // Previous hpd level; also sampled during reset so a steady-high hpd
  // coming out of reset is not mistaken for a plug event.
  always_ff @(posedge clk) begin
    r_hpd_q <= hpd;
  end

  assign w_start_idle = hpd && (cfg_start || !r_hpd_q);
`else
  assign w_start_idle = cfg_start && hpd;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an hpd loss overrides everything while busy.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_idle) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_tc) w_state_nxt = S_ROM_RD;
      end
      S_ROM_RD: begin
        w_state_nxt = S_ROM_LAT;
      end
      S_ROM_LAT: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (i2c_done) begin
          if (!i2c_nack) begin
            w_state_nxt = w_last ? S_DONE : S_ROM_RD;
          end else begin
            w_state_nxt = w_retry_max ? S_ERR : S_REQ_GAP;
          end
        end
      end
      S_REQ_GAP: begin
        w_state_nxt = S_REQ;
      end
      S_DONE: begin
`ifdef ADV7513_HPD_RECFG_EN
        if (!hpd) begin
          w_state_nxt = S_IDLE;
        end else if (cfg_start) begin
          w_state_nxt = S_WAIT;
        end
`else
        if (cfg_start) w_state_nxt = S_WAIT;
`endif
      end
      S_ERR: begin
        if (cfg_start && hpd) w_state_nxt = S_WAIT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_busy_st && !hpd) w_state_nxt = S_IDLE;
  end

  // Settle counter, ROM index and retry counter; all restart on IDLE or a fresh WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_retry    <= '0;
    end else if ((w_state_nxt == S_IDLE) || w_enter_wait) begin
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_retry    <= '0;
    end else begin
      if ((r_state == S_WAIT) && !w_wait_tc) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end
      if ((r_state == S_REQ) && (w_state_nxt == S_ROM_RD)) begin
        r_idx   <= r_idx + IW'(1);
        r_retry <= '0;
      end
      if ((r_state == S_REQ) && (w_state_nxt == S_REQ_GAP)) begin
        r_retry <= r_retry + RW'(1);
      end
    end
  end

  // Outputs registered from the next state so they change with the state itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_dev_addr <= I2C_DEV_ADDR;
      r_reg_addr <= 8'h00;
      r_wdata    <= 8'h00;
    end else begin
      r_req      <= (w_state_nxt == S_REQ);
      r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                    (w_state_nxt != S_ERR);
      r_done     <= (w_state_nxt == S_DONE);
      r_err      <= (w_state_nxt == S_ERR);
      r_dev_addr <= I2C_DEV_ADDR;
      if (r_state == S_ROM_LAT) begin
        r_reg_addr <= rom_rdata[15:8];
        r_wdata    <= rom_rdata[7:0];
      end
    end
  end

  assign rom_addr     = r_idx;
  assign i2c_req      = r_req;
  assign i2c_dev_addr = r_dev_addr;
  assign i2c_reg_addr = r_reg_addr;
  assign i2c_wdata    = r_wdata;
  assign busy         = r_busy;
  assign cfg_done     = r_done;
  assign cfg_err      = r_err;
  assign drvr_en      = r_done;

endmodule

// File: tb/tb_adv7513_cfg_seq.sv
// tb_adv7513_cfg_seq: directed bench for adv7513_cfg_seq with a small ROM
// and an I2C master model that answers every request after 5 cycles.
`timescale 1ns/1ps
module tb_adv7513_cfg_seq;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic        hpd;
  logic [1:0]  rom_addr;
  logic [15:0] rom_rdata;
  logic        i2c_req;
  logic [7:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_wdata;
  logic        i2c_done;
  logic        i2c_nack;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;
  logic        drvr_en;

  logic [15:0] rom [4];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_done_cyc = 0;
  logic [23:0] req_log [$];
  int          rise_log [$];
  logic [7:0]  nack_reg = 8'h00;
  int          nack_left = 0;

  adv7513_cfg_seq #(
    .NUM_REGS    (4),
    .I2C_DEV_ADDR(8'h72),
    .MAX_RETRY   (2),
    .PWRUP_WAIT  (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .hpd         (hpd),
    .rom_addr    (rom_addr),
    .rom_rdata   (rom_rdata),
    .i2c_req     (i2c_req),
    .i2c_dev_addr(i2c_dev_addr),
    .i2c_reg_addr(i2c_reg_addr),
    .i2c_wdata   (i2c_wdata),
    .i2c_done    (i2c_done),
    .i2c_nack    (i2c_nack),
    .busy        (busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .drvr_en     (drvr_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rom[0] = 16'h4110;
    rom[1] = 16'h9803;
    rom[2] = 16'h9A70;
    rom[3] = 16'h9C30;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) rom_rdata <= rom[rom_addr];

  // I2C master model: logs each request rise, answers on its 5th high cycle.
  initial begin : i2c_master
    int   cnt;
    logic req_q;
    cnt = 0;
    req_q = 1'b0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (i2c_req === 1'b1) begin
        if (!req_q) begin
          req_log.push_back({i2c_dev_addr, i2c_reg_addr, i2c_wdata});
          rise_log.push_back(cyc);
          cnt = 0;
        end
        cnt++;
        if (cnt == 5) begin
          i2c_done = 1'b1;
          if ((i2c_reg_addr == nack_reg) && (nack_left > 0)) begin
            i2c_nack = 1'b1;
            nack_left--;
          end
          last_done_cyc = cyc;
        end
      end else begin
        cnt = 0;
      end
      req_q = (i2c_req === 1'b1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic clear_log();
    req_log.delete();
    rise_log.delete();
  endtask

  // sel 0 waits for cfg_done, sel 1 for cfg_err; at = cycle first seen.
  task automatic wait_flag(input int sel, input int budget, output bit hit, output int at);
    hit = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick(1);
      if ((sel == 0 && cfg_done === 1'b1) || (sel == 1 && cfg_err === 1'b1)) begin
        hit = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_start = 1'b0;
    hpd = 1'b1;
    tick(3);
    checks++;
    if ({i2c_req, busy, cfg_done, cfg_err, drvr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req/busy/done/err/drvr=%b want 00000",
               {i2c_req, busy, cfg_done, cfg_err, drvr_en});
    end
    checks++;
    if ({rom_addr, i2c_reg_addr, i2c_wdata} !== 18'h0) begin
      errors++;
      $display("FAIL reset_addr_data: rom_addr=%h reg=%h data=%h want 0", rom_addr,
               i2c_reg_addr, i2c_wdata);
    end
    checks++;
    if (i2c_dev_addr !== 8'h72) begin
      errors++;
      $display("FAIL reset_dev_addr: got %h want 72", i2c_dev_addr);
    end
    rst_n = 1'b1;
    tick(5);
    checks++;
    if (busy !== 1'b0 || req_log.size() != 0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b requests=%0d want 0/0", busy, req_log.size());
    end
  endtask

  task automatic test_nominal();
    bit hit;
    int at;
    clear_log();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nom_busy_rise: busy=%b want 1", busy);
    end
    tick(4);
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    wait_flag(0, 300, hit, at);
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL nom_done_timeout: cfg_done never rose");
    end
    checks++;
    if ({drvr_en, busy, cfg_err} !== 3'b100) begin
      errors++;
      $display("FAIL nom_status: drvr/busy/err=%b want 100", {drvr_en, busy, cfg_err});
    end
    checks++;
    if (at != last_done_cyc + 1) begin
      errors++;
      $display("FAIL nom_drvr_latency: seen cycle %0d want %0d", at, last_done_cyc + 1);
    end
    checks++;
    if (req_log.size() != 4) begin
      errors++;
      $display("FAIL nom_req_count: got %0d want 4", req_log.size());
    end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== {8'h72, rom[i]}) begin
        errors++;
        $display("FAIL nom_req_%0d: got %h want %h", i, req_log[i], {8'h72, rom[i]});
      end
    end
    if (rise_log.size() == 4) begin
      checks++;
      if (rise_log[0] - start_cyc != 12) begin
        errors++;
        $display("FAIL nom_first_req_latency: got %0d want 12", rise_log[0] - start_cyc);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (rise_log[i] - rise_log[i-1] != 7) begin
          errors++;
          $display("FAIL nom_req_spacing_%0d: got %0d want 7", i, rise_log[i] - rise_log[i-1]);
        end
      end
    end
  endtask

  task automatic test_retry();
    bit hit;
    int at;
    int exp_idx [6] = '{0, 1, 1, 1, 2, 3};
    int exp_gap [6] = '{0, 7, 6, 6, 7, 7};
    clear_log();
    nack_reg = 8'h98;
    nack_left = 2;
    pulse_start();
    wait_flag(0, 300, hit, at);
    checks++;
    if (!hit || drvr_en !== 1'b1) begin
      errors++;
      $display("FAIL retry_done: hit=%b drvr_en=%b want 1/1", hit, drvr_en);
    end
    checks++;
    if (req_log.size() != 6) begin
      errors++;
      $display("FAIL retry_req_count: got %0d want 6", req_log.size());
    end
    for (int i = 0; i < 6 && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== {8'h72, rom[exp_idx[i]]}) begin
        errors++;
        $display("FAIL retry_req_%0d: got %h want %h", i, req_log[i], {8'h72, rom[exp_idx[i]]});
      end
      if (i > 0) begin
        checks++;
        if (rise_log[i] - rise_log[i-1] != exp_gap[i]) begin
          errors++;
          $display("FAIL retry_spacing_%0d: got %0d want %0d", i,
                   rise_log[i] - rise_log[i-1], exp_gap[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit hit;
    int at;
    int exp_idx [5] = '{0, 1, 2, 2, 2};
    clear_log();
    nack_reg = 8'h9A;
    nack_left = 1000;
    pulse_start();
    wait_flag(1, 300, hit, at);
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_err_timeout: cfg_err never rose");
    end
    checks++;
    if ({cfg_err, drvr_en, busy, cfg_done} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_status: err/drvr/busy/done=%b want 1000",
               {cfg_err, drvr_en, busy, cfg_done});
    end
    tick(30);
    checks++;
    if (req_log.size() != 5 || i2c_req !== 1'b0 || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL abort_quiet: requests=%0d req=%b err=%b want 5/0/1", req_log.size(),
               i2c_req, cfg_err);
    end
    for (int i = 0; i < 5 && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== {8'h72, rom[exp_idx[i]]}) begin
        errors++;
        $display("FAIL abort_req_%0d: got %h want %h", i, req_log[i], {8'h72, rom[exp_idx[i]]});
      end
    end
    nack_reg = 8'h00;
    nack_left = 0;
  endtask

  task automatic test_hpd_abort();
    bit found;
    bit hit;
    int at;
    clear_log();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (req_log.size() >= 3 && i2c_req === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hpd_abort_wait_req: third request never seen");
    end
    hpd = 1'b0;
    tick(1);
    checks++;
    if ({i2c_req, busy} !== 2'b00 || rom_addr !== 2'd0) begin
      errors++;
      $display("FAIL hpd_abort_drop: req/busy=%b rom_addr=%0d want 00/0", {i2c_req, busy},
               rom_addr);
    end
    tick(20);
    checks++;
    if (req_log.size() != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hpd_abort_idle: requests=%0d busy=%b want 3/0", req_log.size(), busy);
    end
    clear_log();
    hpd = 1'b1;
    pulse_start();
    wait_flag(0, 300, hit, at);
    checks++;
    if (!hit || req_log.size() != 4) begin
      errors++;
      $display("FAIL hpd_abort_restart: done=%b requests=%0d want 1/4", hit, req_log.size());
    end
    if (req_log.size() > 0) begin
      checks++;
      if (req_log[0] !== {8'h72, rom[0]} || rise_log[0] - start_cyc != 12) begin
        errors++;
        $display("FAIL hpd_abort_entry0: got %h at +%0d want %h at +12", req_log[0],
                 rise_log[0] - start_cyc, {8'h72, rom[0]});
      end
    end
  endtask

  task automatic test_hpd_done();
`ifdef ADV7513_HPD_RECFG_EN
    bit hit;
    int at;
    clear_log();
    hpd = 1'b0;
    tick(1);
    checks++;
    if (drvr_en !== 1'b0 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL hpd_done_drop: drvr_en=%b cfg_done=%b want 0/0", drvr_en, cfg_done);
    end
    tick(4);
    hpd = 1'b1;
    wait_flag(0, 300, hit, at);
    checks++;
    if (!hit || req_log.size() != 4) begin
      errors++;
      $display("FAIL hpd_done_rerun: done=%b requests=%0d want 1/4", hit, req_log.size());
    end
`else
    int lows;
    clear_log();
    lows = 0;
    hpd = 1'b0;
    repeat (5) begin
      tick(1);
      if (drvr_en !== 1'b1) lows++;
    end
    hpd = 1'b1;
    repeat (30) begin
      tick(1);
      if (drvr_en !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL hpd_done_drvr_en: drvr_en low for %0d cycles want 0", lows);
    end
    checks++;
    if (req_log.size() != 0 || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL hpd_done_quiet: requests=%0d cfg_done=%b want 0/1", req_log.size(),
               cfg_done);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    bit hit;
    int at;
    clear_log();
    pulse_start();
    tick(4);
    checks++;
    if (busy !== 1'b1 || drvr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_pre: busy=%b drvr_en=%b want 1/0", busy, drvr_en);
    end
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({i2c_req, busy, cfg_done, cfg_err, drvr_en} !== 5'b0 ||
        {rom_addr, i2c_reg_addr, i2c_wdata} !== 18'h0 || i2c_dev_addr !== 8'h72) begin
      errors++;
      $display("FAIL rst_wait_values: ctrl=%b addr/reg/data=%h/%h/%h dev=%h want 0/0/0/0/72",
               {i2c_req, busy, cfg_done, cfg_err, drvr_en}, rom_addr, i2c_reg_addr, i2c_wdata,
               i2c_dev_addr);
    end
    rst_n = 1'b1;
    tick(30);
    checks++;
    if (req_log.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_quiet: requests=%0d busy=%b want 0/0", req_log.size(), busy);
    end
    pulse_start();
    wait_flag(0, 300, hit, at);
    checks++;
    if (!hit || req_log.size() != 4) begin
      errors++;
      $display("FAIL rst_wait_restart: done=%b requests=%0d want 1/4", hit, req_log.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0;
    hpd = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_retry();
    test_abort();
    test_hpd_abort();
    test_hpd_done();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
